// File: rtl/identity_pipe.sv
// -----------------------------------------------------------------------------
// identity_pipe
//
// Elastic chain of DEPTH register stages that moves WIDTH-bit beats from the
// upstream port to the downstream port unmodified and in order. Each stage
// holds one data register and one valid bit. A stage takes a new beat
// whenever it is empty or its own contents are moving on at the same edge.
// This gives full throughput and a fill latency of DEPTH-1 edges.
//
// Parameters
//   WIDTH  data bits per beat (>= 1)
//   DEPTH  number of register stages (>= 1)
//   OCC_W  width of the occupancy output
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset (clears valid bits and data)
//   flush      synchronous clear of all in-flight beats (data left as is)
//   in_valid   upstream beat present
//   in_ready   block accepts the upstream beat this cycle
//   in         upstream data
//   out_valid  downstream beat present (last stage valid register)
//   out_ready  downstream accepts the beat this cycle
//   out        downstream data (last stage data register)
//   occupancy  number of stages currently holding a valid beat
//
// Optional build feature (macro IDENTITY_PIPE_STATS_EN)
//   Defining IDENTITY_PIPE_STATS_EN adds a 32-bit output beat_count. It counts
//   output transfers, wraps naturally, clears on rst and is kept on flush.
//   With the macro undefined, the port and its counter do not exist.
// -----------------------------------------------------------------------------
module identity_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [OCC_W-1:0] occupancy
`ifdef IDENTITY_PIPE_STATS_EN
  ,
  output logic [31:0]      beat_count
`endif
);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Number of set bits in a stage valid vector.
  function automatic logic [OCC_W-1:0] count_valid(input logic [DEPTH-1:0] v);
    logic [OCC_W-1:0] n;
    n = {OCC_W{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      n = n + OCC_W'(v[k]);
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage state
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] valid_r;
  logic [WIDTH-1:0] data_r [DEPTH];
  logic [OCC_W-1:0] occ_r;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic [DEPTH-1:0] ready_s;       // stage k can take a beat at this edge
  logic [DEPTH-1:0] prev_valid_s;  // valid bit offered to stage k
  logic [WIDTH-1:0] prev_data_s [DEPTH];
  logic [DEPTH-1:0] valid_nxt_s;   // valid vector after this edge
  logic [DEPTH-1:0] load_s;        // stage k captures new data at this edge

  // Readiness ripples back from out_ready. A stage is ready when it is empty
  // or the stage ahead is ready. A running scalar is used so that the vector
  // never reads its own bits.
  always_comb begin
    logic rdy_v;
    ready_s = {DEPTH{1'b0}};
    rdy_v   = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy_v      = ~valid_r[k] | rdy_v;
      ready_s[k] = rdy_v;
    end
  end

  // The upstream side of each stage: the input port for stage 0, otherwise
  // the stage just behind it.
  always_comb begin
    prev_valid_s    = {DEPTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      prev_data_s[k] = {WIDTH{1'b0}};
    end
    prev_valid_s[0] = in_valid;
    prev_data_s[0]  = in;
    for (int k = 1; k < DEPTH; k++) begin
      prev_valid_s[k] = valid_r[k-1];
      prev_data_s[k]  = data_r[k-1];
    end
  end

  // Next valid vector and data load enables. A ready stage takes whatever
  // is offered behind it, which may be a bubble. A stage that is not ready
  // holds. Flush empties every stage and drops the offered beat.
  always_comb begin
    valid_nxt_s = valid_r;
    load_s      = {DEPTH{1'b0}};
    if (flush) begin
      valid_nxt_s = {DEPTH{1'b0}};
      load_s      = {DEPTH{1'b0}};
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (ready_s[k]) begin
          valid_nxt_s[k] = prev_valid_s[k];
          load_s[k]      = prev_valid_s[k];
        end else begin
          valid_nxt_s[k] = valid_r[k];
          load_s[k]      = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Stage valid bits and occupancy. Occupancy is registered from the same
  // next-state vector, so it always equals the count of valid stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {DEPTH{1'b0}};
      occ_r   <= {OCC_W{1'b0}};
    end else begin
      valid_r <= valid_nxt_s;
      occ_r   <= count_valid(valid_nxt_s);
    end
  end

  // Stage data registers. These load only when a real beat arrives, so idle
  // stages do not toggle. They are zeroed on reset so that no X is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_r[k] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (load_s[k]) begin
          data_r[k] <= prev_data_s[k];
        end else begin
          data_r[k] <= data_r[k];
        end
      end
    end
  end

`ifdef IDENTITY_PIPE_STATS_EN
  logic        xfer_out_s;
  logic [31:0] beat_count_r;

  // An output transfer is the last stage presenting a beat that the
  // downstream side accepts. This includes an edge where flush is high,
  // because that beat has really left the block.
  always_comb begin
    xfer_out_s = valid_r[DEPTH-1] & out_ready;
  end

  // Output transfer counter. It wraps through zero and is cleared only by
  // rst, not by flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_count_r <= 32'd0;
    end else if (xfer_out_s) begin
      beat_count_r <= beat_count_r + 32'd1;
    end else begin
      beat_count_r <= beat_count_r;
    end
  end

  assign beat_count = beat_count_r;
`else
  // Statistics disabled: no counter state exists in this build.
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // While flush is high every stage empties, so any offered beat is absorbed
  // (and discarded). For that reason in_ready reads 1.
  assign in_ready  = flush | ready_s[0];
  assign out_valid = valid_r[DEPTH-1];
  assign out       = data_r[DEPTH-1];
  assign occupancy = occ_r;

endmodule

// File: doc/identity_pipe.md
IDENTITY_PIPE -- requirements
Module: identity_pipe

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits per beat; SHALL be at least 1.
REQ-002 Parameter DEPTH, default 2: number of register stages; SHALL be at least 1.
REQ-003 Parameter OCC_W, default $clog2(DEPTH+1): occupancy output width.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  synchronous clear of all in-flight beats.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  block accepts the upstream beat this cycle.
REQ-009 in  input  WIDTH  upstream data.
REQ-010 out_valid  output  1  downstream beat present.
REQ-011 out_ready  input  1  downstream accepts the beat this cycle.
REQ-012 out  output  WIDTH  downstream data.
REQ-013 occupancy  output  OCC_W  number of stages currently holding a valid beat.

Function
REQ-014 The block SHALL implement an elastic chain of DEPTH stages, each holding a WIDTH-bit data register and a valid bit.
REQ-015 Data SHALL pass unmodified: every accepted beat SHALL appear on out bit-exact, in acceptance order, with no loss or duplication.
REQ-016 A transfer occurs at a port when valid and ready are both high on a rising edge of clk.
REQ-017 Stage k SHALL be ready when it is empty, or when stage k+1 (or out_ready, for the last stage) is ready.
REQ-018 in_ready SHALL equal the readiness of stage 0; the in_ready combinational path from out_ready is allowed.
REQ-019 A stage that is full and not ready SHALL hold its data and valid bit unchanged.
REQ-020 in_ready SHALL NOT depend on in_valid.
REQ-021 Latency: a beat accepted at edge N into an empty chain with out_ready high SHALL have out_valid high after edge N+DEPTH-1, so that out_valid is observable in cycle N+DEPTH-1.
REQ-022 With out_ready held high and in_valid held high, throughput SHALL be one beat per cycle.
REQ-023 out_valid and out SHALL be driven directly from the last stage's registers.
REQ-024 out SHALL hold stable while out_valid is high and out_ready is low.
REQ-025 occupancy SHALL equal the count of valid stages and SHALL range from 0 to DEPTH.
REQ-026 Full boundary: when occupancy equals DEPTH and out_ready is low, in_ready SHALL be 0.
REQ-027 Simultaneous transfer: when a chain is full and in and out transfer at the same edge, occupancy SHALL stay at DEPTH.
REQ-028 Flush: when flush is high at an edge, all valid bits SHALL clear and any beat offered at that edge SHALL be discarded. While flush is high, in_ready SHALL read 1 and out_valid SHALL reflect the registered state.
REQ-029 Data register contents of invalid stages are don't-care, but SHALL NOT be X after reset.

Reset
REQ-030 When rst is high at an edge, all valid bits SHALL clear, all data registers SHALL load 0, occupancy SHALL read 0, and out SHALL read 0.
REQ-031 rst SHALL take priority over flush and over any transfer; a beat offered during reset SHALL be dropped.
REQ-032 A reset asserted mid-stream SHALL discard all in-flight beats. Operation SHALL resume on the first edge after rst deasserts, with no stale beat emitted.

Configuration
REQ-033 Macro IDENTITY_PIPE_STATS_EN: when defined, the block SHALL add a 32-bit output beat_count that increments by 1 on each output transfer. beat_count SHALL wrap from 0xFFFFFFFF to 0, and SHALL clear on rst but not on flush.
REQ-034 When IDENTITY_PIPE_STATS_EN is undefined, the beat_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=8, DEPTH=3)
REQ-035 Scenario 1: assert rst for 2 cycles with in_valid=1 and in=0xFF -> out_valid=0, out=0x00, occupancy=0, and no beat emitted afterwards.
REQ-036 Scenario 2: into an empty chain with out_ready=1, send the single beat 0xA5 -> out=0xA5 with out_valid high in the 3rd cycle after acceptance, and high for exactly 1 cycle.
REQ-037 Scenario 3: out_ready=0 while sending 0x01, 0x02, 0x03, 0x04 -> the first three are accepted, occupancy=3, in_ready=0, and 0x04 is held off; then raise out_ready -> out sequence is 0x01, 0x02, 0x03, 0x04.
REQ-038 Scenario 4: continuous stream 0x00 to 0xFF with out_ready=1 -> one beat per cycle, output matches input in order, and occupancy stays at 3 in steady state.
REQ-039 Scenario 5: with 2 beats in flight, pulse flush for 1 cycle while offering 0x77 -> occupancy=0 and 0x77 is never seen on out.
REQ-040 Scenario 6: random in_valid and out_ready patterns for 10000 cycles, checked against a reference queue model -> zero mismatches; with IDENTITY_PIPE_STATS_EN defined, beat_count equals the number of output transfers.
